// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: quiz round sequencer with rotating-priority button grab,
// answer countdown, per-player saturating scores and foul exclusion.
`default_nettype none

module quiz_round_ctrl #(
   parameter int TICK_DIV    = 100_000_000,
   parameter int GRAB_SECS   = 9,
   parameter int ANSWER_SECS = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        clear_scores,
   input  logic [3:0]  btn,
   input  logic        judge_ok,
   input  logic        judge_bad,
   output logic [1:0]  state,
   output logic [1:0]  winner,
   output logic        winner_vld,
   output logic [3:0]  excl_mask,
   output logic [3:0]  time_left,
   output logic [15:0] scores,
   output logic        round_end,
   output logic        no_winner
);

   localparam int             CW        = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [3:0]     GRAB_T    = 4'(GRAB_SECS);
   localparam logic [3:0]     ANS_T     = 4'(ANSWER_SECS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ARMED  = 2'd1;
   localparam logic [1:0] S_ANSWER = 2'd2;

   logic [3:0]    btn_q;
   logic [1:0]    rr_ptr;
   logic [CW-1:0] tick_cnt;

   logic [3:0] press;
   logic [3:0] eligible;
   logic       grab_found;
   logic [1:0] grab_idx;
   logic [1:0] scan_idx;
   logic       tick;
   logic       expire;
   logic       ok_only;
   logic       bad_only;
   logic [3:0] cur_score;
   logic [3:0] new_mask;

   assign press     = btn & ~btn_q;
   assign eligible  = press & ~excl_mask;
   assign tick      = (tick_cnt == TICK_LAST);
   assign expire    = tick && (time_left == 4'd1);
   // Contradictory judge pulses cancel each other out.
   assign ok_only   = judge_ok & ~judge_bad;
   assign bad_only  = judge_bad & ~judge_ok;
   assign cur_score = scores[{winner, 2'b00} +: 4];
   assign new_mask  = excl_mask | (4'b0001 << winner);

   // First eligible press scanning upward from the rotating pointer.
   always_comb begin
      grab_found = 1'b0;
      grab_idx   = 2'd0;
      scan_idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         scan_idx = rr_ptr + 2'(k);
         if (!grab_found && eligible[scan_idx]) begin
            grab_found = 1'b1;
            grab_idx   = scan_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         winner     <= 2'd0;
         winner_vld <= 1'b0;
         excl_mask  <= 4'd0;
         time_left  <= 4'd0;
         scores     <= 16'd0;
         round_end  <= 1'b0;
         no_winner  <= 1'b0;
         rr_ptr     <= 2'd0;
         tick_cnt   <= '0;
         btn_q      <= 4'd0;
      end else begin
         btn_q     <= btn;
         round_end <= 1'b0;
         no_winner <= 1'b0;
         case (state)
            S_IDLE: begin
               if (clear_scores) scores <= 16'd0;
               if (start) begin
                  state     <= S_ARMED;
                  time_left <= GRAB_T;
                  excl_mask <= 4'd0;
                  tick_cnt  <= '0;
               end
            end
            S_ARMED: begin
               if (grab_found) begin
                  winner     <= grab_idx;
                  rr_ptr     <= grab_idx + 2'd1;
                  winner_vld <= 1'b1;
                  state      <= S_ANSWER;
                  time_left  <= ANS_T;
                  tick_cnt   <= '0;
               end else if (expire) begin
                  state     <= S_IDLE;
                  time_left <= 4'd0;
                  round_end <= 1'b1;
                  no_winner <= 1'b1;
               end else if (tick) begin
                  tick_cnt  <= '0;
                  time_left <= time_left - 4'd1;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            S_ANSWER: begin
               if (ok_only) begin
                  if (cur_score != 4'hF)
                     scores[{winner, 2'b00} +: 4] <= cur_score + 4'd1;
                  state      <= S_IDLE;
                  winner_vld <= 1'b0;
                  time_left  <= 4'd0;
                  round_end  <= 1'b1;
               end else if (bad_only || expire) begin
                  excl_mask  <= new_mask;
                  winner_vld <= 1'b0;
                  if (new_mask == 4'hF) begin
                     state     <= S_IDLE;
                     time_left <= 4'd0;
                     round_end <= 1'b1;
                     no_winner <= 1'b1;
                  end else begin
                     state     <= S_ARMED;
                     time_left <= GRAB_T;
                     tick_cnt  <= '0;
                  end
               end else if (tick) begin
                  tick_cnt  <= '0;
                  time_left <= time_left - 4'd1;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            default: begin
               state      <= S_IDLE;
               winner_vld <= 1'b0;
               time_left  <= 4'd0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_quiz_round_ctrl.sv
// tb_quiz_round_ctrl: directed vector table plus hand sequences for timing corners.
`default_nettype none

module tb_quiz_round_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        clear_scores = 1'b0;
   logic [3:0]  btn = 4'd0;
   logic        judge_ok = 1'b0;
   logic        judge_bad = 1'b0;
   logic [1:0]  state;
   logic [1:0]  winner;
   logic        winner_vld;
   logic [3:0]  excl_mask;
   logic [3:0]  time_left;
   logic [15:0] scores;
   logic        round_end;
   logic        no_winner;

   int checks = 0;
   int failures = 0;

   quiz_round_ctrl #(.TICK_DIV(4), .GRAB_SECS(3), .ANSWER_SECS(2)) dut (
      .clk(clk), .rst(rst), .start(start), .clear_scores(clear_scores),
      .btn(btn), .judge_ok(judge_ok), .judge_bad(judge_bad),
      .state(state), .winner(winner), .winner_vld(winner_vld),
      .excl_mask(excl_mask), .time_left(time_left), .scores(scores),
      .round_end(round_end), .no_winner(no_winner)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        start;
      logic        clr;
      logic [3:0]  btn;
      logic        ok;
      logic        bad;
      logic [1:0]  st;
      logic [1:0]  win;
      logic        vld;
      logic [3:0]  excl;
      logic [3:0]  tl;
      logic [15:0] sc;
      logic        re;
      logic        nw;
   } vec_t;

   function automatic vec_t V(input logic s, input logic c, input logic [3:0] b,
                              input logic o, input logic bd, input logic [1:0] st,
                              input logic [1:0] w, input logic vl, input logic [3:0] ex,
                              input logic [3:0] tl, input logic [15:0] sc,
                              input logic re, input logic nw);
      vec_t v;
      v.start = s;  v.clr = c;  v.btn = b;  v.ok = o;  v.bad = bd;
      v.st = st;    v.win = w;  v.vld = vl; v.excl = ex; v.tl = tl;
      v.sc = sc;    v.re = re;  v.nw = nw;
      return v;
   endfunction

   task automatic compare(input logic [1:0] st, input logic [1:0] w, input logic vl,
                          input logic [3:0] ex, input logic [3:0] tl, input logic [15:0] sc,
                          input logic re, input logic nw, input string name);
      checks++;
      if ({state, winner, winner_vld, excl_mask, time_left, scores, round_end, no_winner} !==
          {st, w, vl, ex, tl, sc, re, nw}) begin
         failures++;
         $display("FAIL %s: got st=%0d win=%0d vld=%0b excl=%b tl=%0d sc=%h re=%0b nw=%0b; want st=%0d win=%0d vld=%0b excl=%b tl=%0d sc=%h re=%0b nw=%0b",
                  name, state, winner, winner_vld, excl_mask, time_left, scores, round_end, no_winner,
                  st, w, vl, ex, tl, sc, re, nw);
      end
   endtask

   // Inputs apply for one cycle; outputs are compared 1 time unit after the edge.
   task automatic step(input vec_t v, input string name);
      start = v.start; clear_scores = v.clr; btn = v.btn;
      judge_ok = v.ok; judge_bad = v.bad;
      @(posedge clk);
      #1;
      compare(v.st, v.win, v.vld, v.excl, v.tl, v.sc, v.re, v.nw, name);
   endtask

   task automatic do_reset(input string name);
      rst = 1'b1; start = 1'b0; clear_scores = 1'b0; btn = 4'd0;
      judge_ok = 1'b0; judge_bad = 1'b0;
      @(posedge clk);
      #1;
      compare(2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b0, name);
      rst = 1'b0;
   endtask

   vec_t tbl[$];

   initial begin
      // s c btn     ok bad  st win vld excl     tl   scores    re nw
      tbl.push_back(V(1,0,4'b0000,0,0, 1,0,0,4'b0000,4'd3,16'h0000,0,0)); // arm
      tbl.push_back(V(0,0,4'b0110,0,0, 2,1,1,4'b0000,4'd2,16'h0000,0,0)); // rr=0 -> p1
      tbl.push_back(V(0,0,4'b0110,1,0, 0,1,0,4'b0000,4'd0,16'h0010,1,0)); // judge_ok
      tbl.push_back(V(0,0,4'b0000,0,0, 0,1,0,4'b0000,4'd0,16'h0010,0,0));
      tbl.push_back(V(1,0,4'b0000,0,0, 1,1,0,4'b0000,4'd3,16'h0010,0,0));
      tbl.push_back(V(0,0,4'b0110,0,0, 2,2,1,4'b0000,4'd2,16'h0010,0,0)); // rr=2 -> p2
      tbl.push_back(V(0,0,4'b0000,0,1, 1,2,0,4'b0100,4'd3,16'h0010,0,0)); // judge_bad
      tbl.push_back(V(0,0,4'b1000,0,0, 2,3,1,4'b0100,4'd2,16'h0010,0,0));
      tbl.push_back(V(0,0,4'b0000,1,1, 2,3,1,4'b0100,4'd2,16'h0010,0,0)); // both judges
      tbl.push_back(V(0,0,4'b0000,1,0, 0,3,0,4'b0100,4'd0,16'h1010,1,0));
      tbl.push_back(V(1,1,4'b0000,0,0, 1,3,0,4'b0000,4'd3,16'h0000,0,0)); // clear+start
      tbl.push_back(V(0,0,4'b0001,0,0, 2,0,1,4'b0000,4'd2,16'h0000,0,0));
      tbl.push_back(V(0,0,4'b0000,0,1, 1,0,0,4'b0001,4'd3,16'h0000,0,0));
      tbl.push_back(V(0,0,4'b0001,0,0, 1,0,0,4'b0001,4'd3,16'h0000,0,0)); // excluded
      tbl.push_back(V(0,0,4'b0010,0,0, 2,1,1,4'b0001,4'd2,16'h0000,0,0));
      tbl.push_back(V(0,0,4'b0000,0,1, 1,1,0,4'b0011,4'd3,16'h0000,0,0));
      tbl.push_back(V(0,0,4'b1100,0,0, 2,2,1,4'b0011,4'd2,16'h0000,0,0));
      tbl.push_back(V(0,0,4'b0000,0,1, 1,2,0,4'b0111,4'd3,16'h0000,0,0));
      tbl.push_back(V(0,0,4'b1000,0,0, 2,3,1,4'b0111,4'd2,16'h0000,0,0));
      tbl.push_back(V(0,0,4'b0000,0,1, 0,3,0,4'b1111,4'd0,16'h0000,1,1)); // all out
      tbl.push_back(V(0,0,4'b0000,0,0, 0,3,0,4'b1111,4'd0,16'h0000,0,0));

      do_reset("reset");
      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i], $sformatf("vec%0d", i));

      // Held button across arming never wins; grab window runs 12 cycles.
      do_reset("reset_held");
      step(V(0,0,4'b0001,0,0, 0,0,0,4'd0,4'd0,16'h0,0,0), "held_idle");
      step(V(1,0,4'b0001,0,0, 1,0,0,4'd0,4'd3,16'h0,0,0), "held_start");
      for (int k = 1; k < 12; k++)
         step(V(0,0,4'b0001,0,0, 1,0,0,4'd0,4'(3 - k / 4),16'h0,0,0),
              $sformatf("held_wait%0d", k));
      step(V(0,0,4'b0001,0,0, 0,0,0,4'd0,4'd0,16'h0,1,1), "held_expire");
      step(V(0,0,4'b0000,0,0, 0,0,0,4'd0,4'd0,16'h0,0,0), "held_release");
      step(V(1,0,4'b0000,0,0, 1,0,0,4'd0,4'd3,16'h0,0,0), "held_rearm");
      step(V(0,0,4'b0001,0,0, 2,0,1,4'd0,4'd2,16'h0,0,0), "held_repress");

      // Exclusion, ignored re-press, and ANSWER expiry after 8 cycles.
      do_reset("reset_excl");
      step(V(1,0,4'b0000,0,0, 1,0,0,4'b0000,4'd3,16'h0,0,0), "excl_start");
      step(V(0,0,4'b1000,0,0, 2,3,1,4'b0000,4'd2,16'h0,0,0), "excl_grab3");
      step(V(0,0,4'b0000,0,1, 1,3,0,4'b1000,4'd3,16'h0,0,0), "excl_bad");
      step(V(0,0,4'b1000,0,0, 1,3,0,4'b1000,4'd3,16'h0,0,0), "excl_repress3");
      step(V(0,0,4'b0001,0,0, 2,0,1,4'b1000,4'd2,16'h0,0,0), "excl_grab0");
      for (int k = 1; k < 8; k++)
         step(V(0,0,4'b0000,0,0, 2,0,1,4'b1000,4'(2 - k / 4),16'h0,0,0),
              $sformatf("excl_wait%0d", k));
      step(V(0,0,4'b0000,0,0, 1,0,0,4'b1001,4'd3,16'h0,0,0), "excl_expire");

      // Score saturation at 15, then clear_scores ignored in ARMED, honoured in IDLE.
      do_reset("reset_sat");
      for (int n = 1; n <= 16; n++) begin
         step(V(1,0,4'b0000,0,0, 1,(n == 1) ? 2'd0 : 2'd2,0,4'd0,4'd3,
                16'((n - 1 > 15 ? 15 : n - 1) << 8),0,0), $sformatf("sat_start%0d", n));
         step(V(0,0,4'b0100,0,0, 2,2,1,4'd0,4'd2,
                16'((n - 1 > 15 ? 15 : n - 1) << 8),0,0), $sformatf("sat_grab%0d", n));
         step(V(0,0,4'b0000,1,0, 0,2,0,4'd0,4'd0,
                16'((n > 15 ? 15 : n) << 8),1,0), $sformatf("sat_ok%0d", n));
      end
      step(V(1,0,4'b0000,0,0, 1,2,0,4'd0,4'd3,16'h0F00,0,0), "clr_arm");
      step(V(0,1,4'b0000,0,0, 1,2,0,4'd0,4'd3,16'h0F00,0,0), "clr_in_armed");
      step(V(0,0,4'b0100,0,0, 2,2,1,4'd0,4'd2,16'h0F00,0,0), "clr_grab");
      step(V(0,0,4'b0000,1,0, 0,2,0,4'd0,4'd0,16'h0F00,1,0), "clr_ok_sat");
      step(V(0,1,4'b0000,0,0, 0,2,0,4'd0,4'd0,16'h0000,0,0), "clr_in_idle");

      // judge_ok on the expiry edge wins; then reset mid-ANSWER.
      do_reset("reset_corner");
      step(V(1,0,4'b0000,0,0, 1,0,0,4'd0,4'd3,16'h0,0,0), "edge_start");
      step(V(0,0,4'b0010,0,0, 2,1,1,4'd0,4'd2,16'h0,0,0), "edge_grab1");
      for (int k = 1; k < 8; k++)
         step(V(0,0,4'b0000,0,0, 2,1,1,4'd0,4'(2 - k / 4),16'h0,0,0),
              $sformatf("edge_wait%0d", k));
      step(V(0,0,4'b0000,1,0, 0,1,0,4'd0,4'd0,16'h0010,1,0), "edge_ok_expiry");
      step(V(1,0,4'b0000,0,0, 1,1,0,4'd0,4'd3,16'h0010,0,0), "abort_start");
      step(V(0,0,4'b0100,0,0, 2,2,1,4'd0,4'd2,16'h0010,0,0), "abort_grab2");
      do_reset("abort_rst");
      step(V(0,0,4'b0000,0,0, 0,0,0,4'd0,4'd0,16'h0,0,0), "abort_quiet");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Round sequencer and button arbiter for the smart-responder quiz system. It sits between the debounced player buttons and the display/scoring logic. It opens a grab window on a host start pulse and picks one winner per grab with rotating priority. It then runs an answer countdown, applies the host's judgement to per-player saturating scores, and re-arms the round with fouled players excluded.

## Interface
- TICK_DIV, 100_000_000: clk cycles per countdown tick (1 s at 100 MHz); must be ≥ 2.
- GRAB_SECS, 9: ticks allowed for the grab window, 1..15.
- ANSWER_SECS, 5: ticks allowed for an answer, 1..15.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  host pulse; begins a round (honoured only in IDLE).
- clear_scores  in  1  host pulse; zeroes all scores (honoured only in IDLE).
- btn  in  4  debounced player buttons, level, active-high; bit i = player i.
- judge_ok  in  1  host pulse; current answer accepted.
- judge_bad  in  1  host pulse; current answer rejected.
- state  out  2  0 = IDLE, 1 = ARMED, 2 = ANSWER.
- winner  out  2  index of current answering player.
- winner_vld  out  1  high throughout ANSWER.
- excl_mask  out  4  players excluded for the remainder of this round.
- time_left  out  4  remaining ticks of the active window; 0 in IDLE.
- scores  out  16  score of player i in bits [4i+3:4i], unsigned.
- round_end  out  1  one-cycle pulse when a round closes (returns to IDLE).
- no_winner  out  1  one-cycle pulse with round_end when the round closes without a correct answer.

## Operation
- Reset: state = IDLE. winner = 0, winner_vld = 0, excl_mask = 0, time_left = 0, scores = 0, round_end = 0, no_winner = 0. rr_ptr = 0, tick counter = 0, btn_q = 0.
- Press detection: press[i] = btn[i] & ~btn_q[i]. btn_q registers btn every cycle in every state. A button held before or across arming therefore never wins until it is released and pressed again.
- IDLE:
  - start → ARMED, time_left ← GRAB_SECS, excl_mask ← 0.
  - clear_scores zeroes all scores. If it coincides with start, both take effect.
  - judge pulses and presses are ignored.
- ARMED: eligible = press & ~excl_mask.
  - If any bit is eligible, the winner is the first set bit scanning rr_ptr, rr_ptr+1, … mod 4. Then: winner ← that index, rr_ptr ← winner+1 mod 4, state → ANSWER, time_left ← ANSWER_SECS, winner_vld ← 1.
  - If no press occurs and the window expires → IDLE with round_end = no_winner = 1.
- ANSWER:
  - judge_ok: scores[winner] ← scores[winner]+1, saturating at 15. Then → IDLE, round_end = 1, no_winner = 0.
  - judge_bad or window expiry: excl_mask[winner] ← 1.
    - If the new excl_mask = 4'hF → IDLE with round_end = no_winner = 1.
    - Otherwise → ARMED, time_left ← GRAB_SECS.
  - winner_vld drops on leaving ANSWER. winner holds its last value.
- Simultaneous events:
  - judge_ok and judge_bad in the same cycle: both are ignored.
  - A valid judge pulse in the same cycle as window expiry: the judge pulse wins.
  - start outside IDLE: ignored.
  - Presses are ignored in IDLE and ANSWER.
- rst mid-round aborts the round. Everything, including scores, returns to reset values, and no round_end is emitted.

## Timing
- Tick counter: cleared on every entry into ARMED or ANSWER. It counts 0..TICK_DIV-1 while in those states, and a tick occurs when it equals TICK_DIV-1.
- Behaviour on a tick:
  - time_left > 1: time_left decrements.
  - time_left = 1: this is expiry, and the transition registers on that same edge.
- Window lengths: ARMED lasts exactly GRAB_SECS×TICK_DIV cycles and ANSWER exactly ANSWER_SECS×TICK_DIV cycles, absent other events.
- Grab latency: btn rises in cycle n while ARMED → state = ANSWER and winner valid from edge n+1 (one cycle).
- Judge latency: one cycle. The score update and state change are visible after the same edge.
- round_end and no_winner are registered and high for exactly one cycle, in the first IDLE cycle.
- Arming: start in cycle n → state = ARMED at n+1. Presses are evaluated from cycle n+1.

## Test plan
Bench parameters: TICK_DIV = 4, GRAB_SECS = 3, ANSWER_SECS = 2.
- Rotating priority:
  - After reset, start, then btn = 4'b0110 in one cycle → winner = 1, state = 2 one cycle later. judge_ok → scores = 16'h0010, round_end pulse.
  - New round, btn = 4'b0110 again → winner = 2 (rr_ptr = 2).
- Held button: btn = 4'b0001 held from IDLE through start → no grab, expiry after 12 cycles, round_end = no_winner = 1. Release, start, re-press → winner = 0.
- Exclusion and re-arm: start, player 3 grabs, judge_bad → state = 1, excl_mask = 4'b1000, time_left = 3. Player 3 re-press is ignored; player 0 press → winner = 0. Let ANSWER expire after 8 cycles → excl_mask = 4'b1001, state = 1.
- All excluded: players 0–3 each grab and receive judge_bad in turn → after the fourth, state = 0, round_end = no_winner = 1, scores unchanged.
- Saturation and clear: 16 judge_ok rounds for player 2 → scores[11:8] = 15 and holds. clear_scores in IDLE → scores = 0. clear_scores in ARMED → no effect.
- Corner events: judge_ok and judge_bad together → no change. judge_ok on the expiry cycle → score increments and state = 0. rst during ANSWER → all outputs zero on the next cycle.
